// File: rtl/uart_tx.sv
// 8N1 UART transmitter driven by an upstream baud strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_CLK_ENABLE,
  input  logic       i_TX_ENABLE,
  input  logic [7:0] i_DATA_IN,
  output logic       o_TX,
  output logic       o_TX_BUSY
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  if (DATA_BITS != 8) begin : g_bad_data_bits
    $error("uart_tx supports only DATA_BITS = 8");
  end

`ifdef UART_TX_PARITY_EN
  localparam int unsigned STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP   = 3'b011,
    PARITY = 3'b100
  } state_t;
`else
  localparam int unsigned STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   next_idx;

  assign next_idx = IDX_W'(cnt_q + CNT_W'(1));

  // State and output registers; everything advances only on a baud strobe.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (i_CLK_ENABLE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (i_TX_ENABLE) begin
          data_d  = i_DATA_IN;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d    = data_q[0];
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q < LAST_BIT) begin
          cnt_d = cnt_q + CNT_W'(1);
          tx_d  = data_q[next_idx];
        end else begin
          cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
          tx_d    = ^data_q;
          state_d = PARITY;
`else
          tx_d    = 1'b1;
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d    = 1'b1;
        state_d = STOP;
      end
`endif
      STOP: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        data_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_TX      = tx_q;
  assign o_TX_BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table plus scoreboard of expected line bits.
// Build with UART_TX_PARITY_EN defined to check the 8E1 variant.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FL = 11;
  localparam logic [FL-1:0] F28 = 11'b1_0_00101000_0;
  localparam logic [FL-1:0] F02 = 11'b1_1_00000010_0;
  localparam logic [FL-1:0] F3C = 11'b1_0_00111100_0;
`else
  localparam int unsigned FL = 10;
  localparam logic [FL-1:0] F28 = 10'b1_00101000_0;
  localparam logic [FL-1:0] F02 = 10'b1_00000010_0;
  localparam logic [FL-1:0] F3C = 10'b1_00111100_0;
`endif
  localparam int unsigned NV = 7;
  localparam int unsigned BUDGET = 200;

  typedef struct {
    logic [7:0]    data;
    int unsigned   period;
    logic [FL-1:0] frame;   // bit 0 is the first bit on the line
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic        sb[$];
  logic        cur_bit;
  logic        en_edge;
  bit          was_busy;
  bit          mon_on;
  bit          gen_on;
  int unsigned period;
  int unsigned ph;
  int          nbits;
  vec_t        vecs[NV];

  always #5 clk = ~clk;

  uart_tx dut (
    .i_CLK        (clk),
    .i_RESET      (rst),
    .i_CLK_ENABLE (clk_en),
    .i_TX_ENABLE  (tx_en),
    .i_DATA_IN    (tx_data),
    .o_TX         (tx),
    .o_TX_BUSY    (busy)
  );

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample strobe at the edge, check line at the falling edge, update strobe.
  task automatic tick();
    @(posedge clk);
    en_edge = clk_en;
    @(negedge clk);
    if (mon_on) begin
      if (en_edge && busy) begin
        if (sb.size() == 0) begin
          chk_bit("sb_underflow", 1'b1, 1'b0);
        end else begin
          cur_bit = sb.pop_front();
          chk_bit("tx_bit", tx, cur_bit);
        end
        nbits++;
      end else if (busy) begin
        chk_bit("tx_hold", tx, cur_bit);
      end
      if (was_busy && !busy) begin
        chk_int("busy_ticks", nbits, FL);
        chk_bit("idle_line", tx, 1'b1);
        nbits = 0;
      end
    end
    was_busy = busy;
    if (gen_on) begin
      ph = (ph + 1 >= period) ? 0 : ph + 1;
      clk_en = (ph == 0);
    end
  endtask

  task automatic push_frame(input logic [FL-1:0] f);
    for (int i = 0; i < int'(FL); i++) sb.push_back(f[i]);
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n;
    n = 0;
    while (busy !== level && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) chk_bit(name, busy, level);
  endtask

  task automatic send(input logic [7:0] d, input logic [FL-1:0] f);
    tx_data = d;
    tx_en   = 1'b1;
    push_frame(f);
    wait_busy(1'b1, "accept_timeout");
    tx_en   = 1'b0;
    tx_data = ~d;
    wait_busy(1'b0, "frame_timeout");
    repeat (3) tick();
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h28, 1, 11'b1_0_00101000_0};
    vecs[1] = '{8'hA5, 4, 11'b1_0_10100101_0};
    vecs[2] = '{8'hFF, 2, 11'b1_0_11111111_0};
    vecs[3] = '{8'h00, 3, 11'b1_0_00000000_0};
    vecs[4] = '{8'h01, 1, 11'b1_1_00000001_0};
    vecs[5] = '{8'h03, 1, 11'b1_0_00000011_0};
    vecs[6] = '{8'h07, 5, 11'b1_1_00000111_0};
`else
    vecs[0] = '{8'h28, 1, 10'b1_00101000_0};
    vecs[1] = '{8'hA5, 4, 10'b1_10100101_0};
    vecs[2] = '{8'hFF, 2, 10'b1_11111111_0};
    vecs[3] = '{8'h00, 3, 10'b1_00000000_0};
    vecs[4] = '{8'h01, 1, 10'b1_00000001_0};
    vecs[5] = '{8'h03, 1, 10'b1_00000011_0};
    vecs[6] = '{8'h07, 5, 10'b1_00000111_0};
`endif
    rst = 1'b1; clk_en = 1'b0; tx_en = 1'b1; tx_data = 8'h5A;
    mon_on = 1'b0; gen_on = 1'b0; period = 1; ph = 0; nbits = 0;
    was_busy = 1'b0; cur_bit = 1'b1; en_edge = 1'b0;

    // Reset with the strobe low still resets.
    repeat (2) tick();
    chk_bit("rst_tx", tx, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);

    // No strobe: a pending request must not be accepted.
    rst = 1'b0;
    repeat (3) tick();
    chk_bit("nostrobe_busy", busy, 1'b0);
    chk_bit("nostrobe_tx", tx, 1'b1);
    tx_en = 1'b0;
    tick();

    mon_on = 1'b1;
    gen_on = 1'b1;
    foreach (vecs[i]) begin
      period = vecs[i].period;
      ph = 0;
      send(vecs[i].data, vecs[i].frame);
    end

    // Back-to-back with data changing mid-frame.
    period = 1;
    tx_data = 8'h28;
    tx_en = 1'b1;
    push_frame(F28);
    push_frame(F02);
    wait_busy(1'b1, "b2b_accept_timeout");
    tx_data = 8'h0A;
    repeat (3) tick();
    tx_data = 8'h02;
    wait_busy(1'b0, "b2b_first_timeout");
    chk_bit("b2b_gap_tx", tx, 1'b1);
    tick();
    chk_bit("b2b_restart", busy, 1'b1);
    tx_en = 1'b0;
    wait_busy(1'b0, "b2b_second_timeout");
    repeat (3) tick();

    // Reset during data bit 3 aborts the frame.
    mon_on = 1'b0;
    tx_data = 8'hA5;
    tx_en = 1'b1;
    wait_busy(1'b1, "rst_mid_accept_timeout");
    tx_en = 1'b0;
    repeat (4) tick();
    chk_bit("mid_d3_tx", tx, 1'b0);
    chk_bit("mid_d3_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk_bit("mid_rst_tx", tx, 1'b1);
    chk_bit("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    chk_bit("post_rst_idle", busy, 1'b0);
    sb.delete();
    nbits = 0;
    mon_on = 1'b1;
    send(8'h3C, F3C);

    chk_int("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
